// File: rtl/can_pkg.sv
// Shared CAN definitions: CRC-15 polynomial, field lengths, tx state encoding
// and the bit-serial CRC step used by both the transmit and receive blocks.
package can_pkg;

  localparam logic [14:0] CRC15_POLY = 15'h4599;

  localparam int CRC_LEN   = 15;
  localparam int EOF_LEN   = 7;
  localparam int IFS_LEN   = 3;
  localparam int FRAME_MAX = 83;
  localparam int FRAME_MIN = 19;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FRAME,
    ST_CRC,
    ST_CRC_DELIM,
    ST_ACK,
    ST_ACK_DELIM,
    ST_EOF,
    ST_IFS
  } tx_state_e;

  // One CRC-15 shift step for a single serial bit.
  function automatic logic [14:0] crc15_step(input logic [14:0] crc, input logic din);
    logic nxt;
    nxt = din ^ crc[14];
    return {crc[13:0], 1'b0} ^ (nxt ? CRC15_POLY : 15'h0000);
  endfunction

endpackage

// File: rtl/can_crc_tx_if.sv
// Request / status bundle between a frame producer and the CAN CRC transmitter.
interface can_crc_tx_if;
  import can_pkg::*;

  logic                   start;
  logic [FRAME_MAX-1:0]   frame_bits;
  logic [6:0]             frame_len;
  logic                   tx;
  logic                   stuff_en;
  logic                   ack_slot;
  logic                   busy;
  logic                   done;
  logic                   len_err;
  logic [CRC_LEN-1:0]     crc;
  logic                   crc_valid;

  modport master (
    output start, frame_bits, frame_len,
    input  tx, stuff_en, ack_slot, busy, done, len_err, crc, crc_valid
  );

  modport slave (
    input  start, frame_bits, frame_len,
    output tx, stuff_en, ack_slot, busy, done, len_err, crc, crc_valid
  );

endinterface

// File: rtl/can_bit_timer.sv
// Free-running bit-time divider: counts 0..CLKS_PER_BIT-1 while enabled,
// parked at 0 otherwise, flags the last clock of each bit.
module can_bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic bit_end
);

  localparam int W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  logic [W-1:0] cnt;

  // Bit-time counter, cleared whenever the transmitter is idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          cnt <= '0;
    else if (!en)                        cnt <= '0;
    else if (cnt == W'(CLKS_PER_BIT-1))  cnt <= '0;
    else                                 cnt <= cnt + W'(1);
  end

  assign bit_end = en && (cnt == W'(CLKS_PER_BIT-1));

endmodule

// File: rtl/can_crc_tx.sv
// CAN 2.0A transmit serialiser: sends a latched frame head MSB-first, appends
// CRC-15 computed on the fly, then the recessive delimiter/ACK/EOF/IFS tail.
module can_crc_tx
  import can_pkg::*;
#(
  parameter int CLK_FREQ_MHZ  = 1,
  parameter int BIT_RATE_KBPS = 250
) (
  input  logic        clk,
  input  logic        rst_n,
  can_crc_tx_if.slave bus
);

  // Must divide exactly and be at least 2.
  localparam int CLKS_PER_BIT = CLK_FREQ_MHZ * 1000 / BIT_RATE_KBPS;

  tx_state_e            state, state_nxt;
  logic [FRAME_MAX-1:0] sh;          // frame head, current bit at the top
  logic [6:0]           len_q;
  logic [6:0]           cnt;         // bit index within the current field
  logic [CRC_LEN-1:0]   crc_q;       // running / frozen CRC
  logic [CRC_LEN-1:0]   crc_sh;      // copy shifted out during the CRC field
  logic [CRC_LEN-1:0]   crc_next;
  logic                 crc_valid_q;
  logic                 done_q;
  logic                 len_err_q;
  logic                 bit_end;
  logic                 field_last;
  logic                 step;
  logic                 len_ok;
  logic                 accept;

  can_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (state != ST_IDLE),
    .bit_end (bit_end)
  );

  assign len_ok   = (bus.frame_len >= 7'(FRAME_MIN)) && (bus.frame_len <= 7'(FRAME_MAX));
  assign accept   = bus.start && (state == ST_IDLE) && len_ok;
  assign crc_next = crc15_step(crc_q, sh[FRAME_MAX-1]);
  assign step     = bit_end && field_last;

  // Last bit of the current field; single-bit fields always end on bit_end.
  always_comb begin
    field_last = 1'b1;
    case (state)
      ST_FRAME: field_last = (cnt == len_q - 7'd1);
      ST_CRC:   field_last = (cnt == 7'(CRC_LEN - 1));
      ST_EOF:   field_last = (cnt == 7'(EOF_LEN - 1));
      ST_IFS:   field_last = (cnt == 7'(IFS_LEN - 1));
      default:  field_last = 1'b1;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: walk the fixed field sequence, one field per step.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (accept) state_nxt = ST_FRAME;
      ST_FRAME:     if (step)   state_nxt = ST_CRC;
      ST_CRC:       if (step)   state_nxt = ST_CRC_DELIM;
      ST_CRC_DELIM: if (step)   state_nxt = ST_ACK;
      ST_ACK:       if (step)   state_nxt = ST_ACK_DELIM;
      ST_ACK_DELIM: if (step)   state_nxt = ST_EOF;
      ST_EOF:       if (step)   state_nxt = ST_IFS;
      ST_IFS:       if (step)   state_nxt = ST_IDLE;
      default:                  state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; everything past the CRC field is recessive.
  always_comb begin
    bus.tx       = 1'b1;
    bus.stuff_en = 1'b0;
    bus.ack_slot = 1'b0;
    bus.busy     = (state != ST_IDLE);
    case (state)
      ST_FRAME: begin
        bus.tx       = sh[FRAME_MAX-1];
        bus.stuff_en = 1'b1;
      end
      ST_CRC: begin
        bus.tx       = crc_sh[CRC_LEN-1];
        bus.stuff_en = 1'b1;
      end
      ST_ACK:  bus.ack_slot = 1'b1;
      default: ;
    endcase
  end

  // Datapath: latch on accept, shift frame and CRC at each bit end, pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh          <= '0;
      len_q       <= '0;
      cnt         <= '0;
      crc_q       <= '0;
      crc_sh      <= '0;
      crc_valid_q <= 1'b0;
      done_q      <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      len_err_q <= 1'b0;
      if (state == ST_IDLE) begin
        if (accept) begin
          sh          <= bus.frame_bits;
          len_q       <= bus.frame_len;
          cnt         <= '0;
          crc_q       <= '0;
          crc_valid_q <= 1'b0;
        end else if (bus.start) begin
          len_err_q <= 1'b1;
        end
      end else if (bit_end) begin
        cnt <= field_last ? 7'd0 : cnt + 7'd1;
        case (state)
          ST_FRAME: begin
            sh    <= sh << 1;
            crc_q <= crc_next;
            if (field_last) begin
              crc_sh      <= crc_next;
              crc_valid_q <= 1'b1;
            end
          end
          ST_CRC: crc_sh <= crc_sh << 1;
          ST_IFS: if (field_last) done_q <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign bus.crc       = crc_q;
  assign bus.crc_valid = crc_valid_q;
  assign bus.done      = done_q;
  assign bus.len_err   = len_err_q;

endmodule

// File: tb/tb_can_crc_tx.sv
// Bench for can_crc_tx: expected bit streams come from CRC-15 as polynomial
// long division of the frame head, plus the fixed recessive tail.
module tb_can_crc_tx;

  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  can_crc_tx_if bus();

  can_crc_tx #(.CLK_FREQ_MHZ(1), .BIT_RATE_KBPS(250)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          n_chk = 0;
  int          n_err = 0;
  logic        exp_bit [0:127];
  logic [14:0] exp_crc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Remainder of M(x)*x^15 / G(x), G = x^15+x^14+x^10+x^8+x^7+x^4+x^3+1.
  task automatic build(input logic [82:0] fb, input int len);
    logic        m [0:127];
    logic [15:0] g;
    g = 16'hC599;
    for (int i = 0; i < 128; i++) m[i] = 1'b0;
    for (int i = 0; i < len; i++) m[i] = fb[82-i];
    for (int i = 0; i < len; i++)
      if (m[i]) for (int j = 0; j < 16; j++) m[i+j] = m[i+j] ^ g[15-j];
    for (int k = 0; k < 15; k++) exp_crc[14-k] = m[len+k];
    for (int i = 0; i < len; i++) exp_bit[i] = fb[82-i];
    for (int k = 0; k < 15; k++) exp_bit[len+k] = exp_crc[14-k];
    for (int i = len + 15; i < len + 28; i++) exp_bit[i] = 1'b1;
  endtask

  task automatic kick(input logic [82:0] fb, input int len);
    bus.frame_bits = fb;
    bus.frame_len  = 7'(len);
    bus.start      = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Checks every cycle of the frame; returns on the done-cycle negedge.
  task automatic check_frame(input int len, input bit mid_start);
    int b;
    for (int i = 0; i < (len + 28) * CPB; i++) begin
      @(negedge clk);
      b = i / CPB;
      chk("tx",        bus.tx,        exp_bit[b]);
      chk("busy",      bus.busy,      1);
      chk("stuff_en",  bus.stuff_en,  b < len + 15);
      chk("ack_slot",  bus.ack_slot,  b == len + 16);
      chk("crc_valid", bus.crc_valid, b >= len);
      chk("done_low",  bus.done,      0);
      if (b >= len) chk("crc_hold", bus.crc, exp_crc);
      if (mid_start) begin
        if (i == 20) begin
          bus.start     = 1'b1;
          bus.frame_len = 7'd19;
        end else if (i == 21) begin
          bus.start = 1'b0;
        end
      end
    end
    @(negedge clk);
    chk("done_pulse", bus.done,      1);
    chk("busy_end",   bus.busy,      0);
    chk("tx_end",     bus.tx,        1);
    chk("crc_end",    bus.crc,       exp_crc);
    chk("valid_end",  bus.crc_valid, 1);
  endtask

  task automatic run(input logic [82:0] fb, input int len, input bit mid_start);
    build(fb, len);
    kick(fb, len);
    check_frame(len, mid_start);
  endtask

  task automatic idle_chk();
    @(negedge clk);
    chk("done_once", bus.done, 0);
    chk("idle_busy", bus.busy, 0);
    chk("idle_tx",   bus.tx,   1);
  endtask

  task automatic len_bad(input int len);
    @(negedge clk);
    bus.frame_len = 7'(len);
    bus.start     = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    chk("len_err_hi", bus.len_err, 1);
    chk("len_busy",   bus.busy,    0);
    chk("len_tx",     bus.tx,      1);
    @(negedge clk);
    chk("len_err_lo", bus.len_err, 0);
    chk("len_busy2",  bus.busy,    0);
  endtask

  function automatic logic [82:0] rnd_frame();
    logic [82:0] fb;
    fb[82:64] = 19'($urandom);
    fb[63:32] = $urandom;
    fb[31:0]  = $urandom;
    return fb;
  endfunction

  initial begin
    logic [82:0] fb;
    int          len;

    bus.start      = 1'b0;
    bus.frame_bits = '0;
    bus.frame_len  = '0;

    repeat (3) @(negedge clk);
    chk("rst_tx",        bus.tx,        1);
    chk("rst_busy",      bus.busy,      0);
    chk("rst_stuff",     bus.stuff_en,  0);
    chk("rst_ack",       bus.ack_slot,  0);
    chk("rst_done",      bus.done,      0);
    chk("rst_len_err",   bus.len_err,   0);
    chk("rst_crc",       bus.crc,       0);
    chk("rst_crc_valid", bus.crc_valid, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // All-zero minimum frame: CRC 0.
    run(83'h0, 19, 1'b0);
    chk("crc_zero", bus.crc, 15'h0000);
    idle_chk();

    // Single trailing one: CRC equals the polynomial.
    fb = '0;
    fb[64] = 1'b1;
    run(fb, 19, 1'b0);
    chk("crc_poly", bus.crc, 15'h4599);
    idle_chk();

    // Full-length frame.
    fb = {60'h0C1108000108750, 23'h0};
    run(fb, 83, 1'b0);
    idle_chk();

    // Out-of-range lengths.
    len_bad(18);
    len_bad(84);
    len_bad(0);
    len_bad(127);

    // start while busy is ignored.
    @(negedge clk);
    run(rnd_frame(), $urandom_range(83, 19), 1'b1);
    idle_chk();

    // start on the done cycle: no idle gap between frames.
    run(rnd_frame(), $urandom_range(83, 19), 1'b0);
    run(rnd_frame(), $urandom_range(83, 19), 1'b0);
    run(rnd_frame(), 83, 1'b0);
    idle_chk();

    // Random frames including the length boundaries.
    for (int t = 0; t < 8; t++) begin
      len = (t == 0) ? 19 : (t == 1) ? 83 : int'($urandom_range(83, 19));
      run(rnd_frame(), len, 1'b0);
      idle_chk();
    end

    // Reset in the middle of the CRC field.
    len = $urandom_range(60, 19);
    fb  = rnd_frame();
    build(fb, len);
    kick(fb, len);
    repeat ((len + 5) * CPB) @(negedge clk);
    chk("pre_rst_stuff", bus.stuff_en, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_tx",    bus.tx,        1);
    chk("arst_busy",  bus.busy,      0);
    chk("arst_crc",   bus.crc,       0);
    chk("arst_valid", bus.crc_valid, 0);
    chk("arst_stuff", bus.stuff_en,  0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("arst_no_done", bus.done, 0);
      chk("arst_idle",    bus.busy, 0);
    end
    run(rnd_frame(), $urandom_range(83, 19), 1'b0);
    idle_chk();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
